// File: rtl/instr_mem_multiport.sv
// Shared instruction memory with NUM_CORES registered fetch ports and one program-load
// write port. After reset a clear sequencer sweeps the array to all-zero (NOP), one
// word per cycle, before any fetch or program write is accepted.
// Optional macro IMEM_WRITE_BYPASS_EN: same-cycle fetch of the word being programmed
// returns the new data (write-first) instead of the old contents (read-first).
module instr_mem_multiport #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          fetch_req,
    input  logic [NUM_CORES*ADDR_W-1:0]   fetch_addr,
    output logic [NUM_CORES-1:0]          fetch_gnt,
    output logic [NUM_CORES-1:0]          fetch_valid,
    output logic [NUM_CORES*DATA_W-1:0]   fetch_instr,
    output logic [NUM_CORES-1:0]          fetch_fault,
    input  logic                          prog_valid,
    output logic                          prog_ready,
    input  logic [ADDR_W-1:0]             prog_addr,
    input  logic [DATA_W-1:0]             prog_data,
    output logic                          init_done
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e                      state_q;
    logic [IDX_W-1:0]            clear_ptr_q;
    logic                        init_done_q;
    logic [NUM_CORES-1:0]        fetch_valid_q;
    logic [NUM_CORES-1:0]        fetch_fault_q;
    logic [NUM_CORES*DATA_W-1:0] fetch_instr_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0]    prog_word;
    logic                 prog_ok;
    logic                 prog_we;
    logic [IDX_W-1:0]     prog_idx;
    logic [ADDR_W-1:0]    fetch_word [NUM_CORES];
    logic [IDX_W-1:0]     fetch_idx  [NUM_CORES];
    logic [DATA_W-1:0]    rd_data    [NUM_CORES];
    logic [NUM_CORES-1:0] fetch_ok;

    // Handshakes: nothing is accepted until the clear sweep has finished.
    always_comb begin
        prog_ready = (state_q == StRun);
        fetch_gnt  = prog_ready ? fetch_req : '0;
    end

    // Program-port decode; range check uses the full word index, not the truncated one.
    always_comb begin
        prog_word = prog_addr >> 2;
        prog_ok   = (prog_addr[1:0] == 2'b00) && (prog_word < ADDR_W'(DEPTH));
        prog_idx  = prog_word[IDX_W-1:0];
        prog_we   = prog_valid && prog_ready && prog_ok;
    end

    // Per-core fetch decode and array read (old contents unless forwarding is built).
    always_comb begin
        fetch_ok = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            fetch_word[c] = fetch_addr[c*ADDR_W +: ADDR_W] >> 2;
            fetch_idx[c]  = fetch_word[c][IDX_W-1:0];
            fetch_ok[c]   = (fetch_addr[c*ADDR_W +: 2] == 2'b00)
                            && (fetch_word[c] < ADDR_W'(DEPTH));
            rd_data[c]    = fetch_ok[c] ? mem[fetch_idx[c]] : '0;
`ifdef IMEM_WRITE_BYPASS_EN
            if (prog_we && fetch_ok[c] && (fetch_idx[c] == prog_idx)) begin
                rd_data[c] = prog_data;
            end
`endif
        end
    end

    // Clear/run sequencer; init_done is registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StClear;
            clear_ptr_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    if (clear_ptr_q == IDX_W'(DEPTH - 1)) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end else begin
                        clear_ptr_q <= clear_ptr_q + 1'b1;
                    end
                end
                StRun:   state_q <= StRun;
                default: state_q <= StClear;
            endcase
        end
    end

    // Single array write port, shared by the clear sweep and the program loader.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[clear_ptr_q] <= '0;
        end else if (prog_we) begin
            mem[prog_idx] <= prog_data;
        end
    end

    // Registered fetch responses; instruction slice holds when its core is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_valid_q <= '0;
            fetch_fault_q <= '0;
            fetch_instr_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                fetch_valid_q[c] <= fetch_gnt[c];
                fetch_fault_q[c] <= fetch_gnt[c] && !fetch_ok[c];
                if (fetch_gnt[c]) begin
                    fetch_instr_q[c*DATA_W +: DATA_W] <= rd_data[c];
                end
            end
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fetch_instr = fetch_instr_q;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_instr_mem_multiport.sv
// Directed self-checking bench for instr_mem_multiport (2 cores, 32-bit, 64 words).
module tb_instr_mem_multiport;

    localparam int NC = 2;
    localparam int DW = 32;
    localparam int DP = 64;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     fetch_req;
    logic [NC*AW-1:0]  fetch_addr;
    logic [NC-1:0]     fetch_gnt;
    logic [NC-1:0]     fetch_valid;
    logic [NC*DW-1:0]  fetch_instr;
    logic [NC-1:0]     fetch_fault;
    logic              prog_valid;
    logic              prog_ready;
    logic [AW-1:0]     prog_addr;
    logic [DW-1:0]     prog_data;
    logic              init_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] model [DP];

    instr_mem_multiport #(
        .NUM_CORES(NC),
        .DATA_W   (DW),
        .DEPTH    (DP),
        .ADDR_W   (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_gnt  (fetch_gnt),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_fault(fetch_fault),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cycles;
        int bad;
        reset      = 1'b0;
        fetch_req  = 2'b11;
        fetch_addr = '0;
        prog_valid = 1'b1;
        prog_addr  = 32'h0;
        prog_data  = 32'hFFFF_FFFF;
        repeat (3) step();
        n_cmp++;
        if (init_done !== 1'b0) begin
            n_err++; $display("FAIL reset_init_done: got %b expected 0", init_done);
        end
        n_cmp++;
        if (fetch_valid !== 2'b00 || fetch_fault !== 2'b00) begin
            n_err++;
            $display("FAIL reset_valid_fault: got %b/%b expected 00/00", fetch_valid, fetch_fault);
        end
        n_cmp++;
        if (fetch_instr !== '0) begin
            n_err++; $display("FAIL reset_instr: got %h expected 0", fetch_instr);
        end
        n_cmp++;
        if (fetch_gnt !== 2'b00 || prog_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_handshake: got gnt=%b ready=%b expected 00/0", fetch_gnt,
                     prog_ready);
        end
        reset  = 1'b1;
        cycles = 0;
        bad    = 0;
        while (init_done !== 1'b1 && cycles < 200) begin
            if (fetch_gnt !== 2'b00 || prog_ready !== 1'b0 || fetch_valid !== 2'b00) bad++;
            step();
            cycles++;
        end
        n_cmp++;
        if (cycles !== 64) begin
            n_err++; $display("FAIL sweep_length: got %0d cycles expected 64", cycles);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL sweep_no_grant: got %0d bad cycles expected 0", bad);
        end
        prog_valid = 1'b0;
        fetch_req  = 2'b01;
        fetch_addr = {32'h0, 32'h08};
        #1;
        n_cmp++;
        if (fetch_gnt !== 2'b01) begin
            n_err++; $display("FAIL run_gnt: got %b expected 01", fetch_gnt);
        end
        step();
        n_cmp++;
        if (fetch_valid !== 2'b01 || fetch_instr[DW-1:0] !== 32'h0 || fetch_fault !== 2'b00) begin
            n_err++;
            $display("FAIL first_fetch: got v=%b i=%h f=%b expected 01/00000000/00",
                     fetch_valid, fetch_instr[DW-1:0], fetch_fault);
        end
    endtask

    task automatic test_program();
        fetch_req  = 2'b00;
        prog_valid = 1'b1;
        prog_addr  = 32'h00;
        prog_data  = 32'h2008_0003;
        #1;
        n_cmp++;
        if (prog_ready !== 1'b1) begin
            n_err++; $display("FAIL prog_ready: got %b expected 1", prog_ready);
        end
        step();
        prog_addr = 32'h04;
        prog_data = 32'h2009_0007;
        step();
        model[0]   = 32'h2008_0003;
        model[1]   = 32'h2009_0007;
        prog_valid = 1'b0;
        fetch_req  = 2'b11;
        fetch_addr = {32'h04, 32'h00};
        step();
        n_cmp++;
        if (fetch_valid !== 2'b11 || fetch_instr !== {32'h2009_0007, 32'h2008_0003}) begin
            n_err++;
            $display("FAIL program_fetch: got v=%b i=%h expected 11/2009000720080003",
                     fetch_valid, fetch_instr);
        end
    endtask

    task automatic test_same_addr();
        fetch_req  = 2'b00;
        prog_valid = 1'b1;
        prog_addr  = 32'h10;
        prog_data  = 32'hAC0A_0010;
        step();
        model[4]   = 32'hAC0A_0010;
        prog_valid = 1'b0;
        fetch_req  = 2'b11;
        fetch_addr = {32'h10, 32'h10};
        #1;
        n_cmp++;
        if (fetch_gnt !== 2'b11) begin
            n_err++; $display("FAIL same_addr_gnt: got %b expected 11", fetch_gnt);
        end
        step();
        n_cmp++;
        if (fetch_valid !== 2'b11 || fetch_instr !== {32'hAC0A_0010, 32'hAC0A_0010}) begin
            n_err++;
            $display("FAIL same_addr_fetch: got v=%b i=%h expected 11/AC0A0010AC0A0010",
                     fetch_valid, fetch_instr);
        end
    endtask

    task automatic test_fault();
        int sweep_err;
        fetch_req  = 2'b01;
        fetch_addr = {32'h0, 32'h102};
        step();
        n_cmp++;
        if (fetch_valid !== 2'b01 || fetch_fault !== 2'b01 || fetch_instr[DW-1:0] !== 32'h0) begin
            n_err++;
            $display("FAIL misaligned: got v=%b f=%b i=%h expected 01/01/00000000",
                     fetch_valid, fetch_fault, fetch_instr[DW-1:0]);
        end
        n_cmp++;
        if (fetch_instr[2*DW-1:DW] !== 32'hAC0A_0010) begin
            n_err++;
            $display("FAIL idle_hold: got %h expected ac0a0010", fetch_instr[2*DW-1:DW]);
        end
        fetch_addr = {32'h0, 32'h100};
        step();
        n_cmp++;
        if (fetch_valid !== 2'b01 || fetch_fault !== 2'b01 || fetch_instr[DW-1:0] !== 32'h0) begin
            n_err++;
            $display("FAIL out_of_range: got v=%b f=%b i=%h expected 01/01/00000000",
                     fetch_valid, fetch_fault, fetch_instr[DW-1:0]);
        end
        fetch_req  = 2'b00;
        prog_valid = 1'b1;
        prog_addr  = 32'h100;
        prog_data  = 32'hDEAD_BEEF;
        step();
        n_cmp++;
        if (fetch_valid !== 2'b00 || fetch_fault !== 2'b00) begin
            n_err++;
            $display("FAIL no_req: got v=%b f=%b expected 00/00", fetch_valid, fetch_fault);
        end
        prog_addr = 32'h06;
        prog_data = 32'h5555_5555;
        step();
        prog_valid = 1'b0;
        sweep_err  = 0;
        fetch_req  = 2'b01;
        for (int i = 0; i < DP; i++) begin
            fetch_addr = {32'h0, 32'(i * 4)};
            step();
            n_cmp++;
            if (fetch_instr[DW-1:0] !== model[i] || fetch_fault !== 2'b00) begin
                n_err++;
                sweep_err++;
                $display("FAIL sweep_word_%0d: got %h f=%b expected %h f=00", i,
                         fetch_instr[DW-1:0], fetch_fault, model[i]);
            end
        end
        fetch_req = 2'b00;
    endtask

    task automatic test_rw_collision();
        logic [DW-1:0] exp_first;
`ifdef IMEM_WRITE_BYPASS_EN
        exp_first = 32'h0109_5020;
`else
        exp_first = 32'h0;
`endif
        prog_valid = 1'b1;
        prog_addr  = 32'h08;
        prog_data  = 32'h0109_5020;
        fetch_req  = 2'b10;
        fetch_addr = {32'h08, 32'h0};
        step();
        model[2]   = 32'h0109_5020;
        prog_valid = 1'b0;
        n_cmp++;
        if (fetch_valid !== 2'b10 || fetch_instr[2*DW-1:DW] !== exp_first) begin
            n_err++;
            $display("FAIL rw_same_cycle: got v=%b i=%h expected 10/%h", fetch_valid,
                     fetch_instr[2*DW-1:DW], exp_first);
        end
        step();
        n_cmp++;
        if (fetch_instr[2*DW-1:DW] !== 32'h0109_5020) begin
            n_err++;
            $display("FAIL rw_refetch: got %h expected 01095020", fetch_instr[2*DW-1:DW]);
        end
        fetch_req = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [5];
        addrs[0] = 32'h00; addrs[1] = 32'h04; addrs[2] = 32'h08;
        addrs[3] = 32'h10; addrs[4] = 32'h0C;
        fetch_req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            fetch_addr = {32'h0, addrs[i]};
            step();
            n_cmp++;
            if (fetch_valid !== 2'b01 || fetch_instr[DW-1:0] !== model[addrs[i] >> 2]) begin
                n_err++;
                $display("FAIL back_to_back_%0d: got v=%b i=%h expected 01/%h", i,
                         fetch_valid, fetch_instr[DW-1:0], model[addrs[i] >> 2]);
            end
        end
        fetch_req = 2'b00;
    endtask

    task automatic test_mid_reset();
        int cycles;
        fetch_req  = 2'b11;
        fetch_addr = {32'h04, 32'h00};
        step();
        n_cmp++;
        if (fetch_valid !== 2'b11) begin
            n_err++; $display("FAIL pre_reset_valid: got %b expected 11", fetch_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (fetch_valid !== 2'b00 || fetch_instr !== '0 || init_done !== 1'b0) begin
            n_err++;
            $display("FAIL async_drop: got v=%b i=%h d=%b expected 00/0/0", fetch_valid,
                     fetch_instr, init_done);
        end
        step();
        step();
        reset = 1'b1;
        repeat (10) step();
        // reset again part-way through the sweep: it must restart from word 0
        reset = 1'b0;
        step();
        reset  = 1'b1;
        cycles = 0;
        while (init_done !== 1'b1 && cycles < 200) begin
            step();
            cycles++;
        end
        n_cmp++;
        if (cycles !== 64) begin
            n_err++; $display("FAIL resweep_length: got %0d cycles expected 64", cycles);
        end
        fetch_req  = 2'b11;
        fetch_addr = {32'h04, 32'h00};
        step();
        n_cmp++;
        if (fetch_valid !== 2'b11 || fetch_instr !== '0) begin
            n_err++;
            $display("FAIL rezeroed: got v=%b i=%h expected 11/0", fetch_valid, fetch_instr);
        end
        fetch_req = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < DP; i++) model[i] = '0;
        reset      = 1'b0;
        fetch_req  = '0;
        fetch_addr = '0;
        prog_valid = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        test_reset();
        test_program();
        test_same_addr();
        test_fault();
        test_rw_collision();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_mem_multiport.md
Name: instr_mem_multiport

Overview:
Parametrised, shared instruction memory serving NUM_CORES fetch ports from one array, with a registered 1-cycle read per port. A program-load write port lets the testbench or a boot loader write instructions at run time instead of fixing them at elaboration. After reset, a clear sequencer zeroes the array to all-NOP before any fetch is granted. The block sits between the per-core PC/fetch stages and the boot/program loader.

Parameters:
NUM_CORES, 2, number of independent fetch ports
DATA_W, 32, instruction width in bits
DEPTH, 64, number of instruction words (any value >= 2; need not be a power of 2)
ADDR_W, 32, byte-address width on fetch and program ports

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
fetch_req  in  NUM_CORES  per-core fetch request
fetch_addr  in  NUM_CORES*ADDR_W  per-core byte address; core c uses [c*ADDR_W +: ADDR_W]
fetch_gnt  out  NUM_CORES  request accepted this cycle
fetch_valid  out  NUM_CORES  fetch_instr slice valid (registered)
fetch_instr  out  NUM_CORES*DATA_W  per-core instruction; core c uses [c*DATA_W +: DATA_W]
fetch_fault  out  NUM_CORES  qualifies fetch_valid: address misaligned or out of range
prog_valid  in  1  program-write request
prog_ready  out  1  program write accepted when prog_valid=1
prog_addr  in  ADDR_W  byte address of the word to write
prog_data  in  DATA_W  instruction word to write
init_done  out  1  1 once the clear sweep is complete

Behaviour:
- Word index = addr >> 2, width clog2(DEPTH). An address is in range when the full (addr >> 2) < DEPTH. It is aligned when addr[1:0] == 0.
- FSM has two states: CLEAR and RUN.
- While reset is low: state = CLEAR, clear_ptr = 0, and fetch_valid, fetch_fault, fetch_instr and init_done are all 0. The array itself is not asynchronously reset.
- CLEAR state:
  - Each cycle writes 0 to mem[clear_ptr], then clear_ptr increments.
  - After the write of DEPTH-1, the FSM moves to RUN and init_done goes 1. The sweep takes exactly DEPTH cycles after reset is released.
  - fetch_gnt = 0 and prog_ready = 0 throughout.
- RUN state:
  - fetch_gnt = fetch_req (combinational). All cores are served in the same cycle, with no arbitration, including when several cores present the same address.
  - An accepted fetch on core c produces, at the next rising edge: fetch_valid[c] = 1, and fetch_instr slice = mem[index].
  - If the address is out of range or misaligned: fetch_instr slice = 0 (NOP) and fetch_fault[c] = 1 for that one cycle.
  - If there is no request: fetch_valid[c] = 0, fetch_fault[c] = 0, and the fetch_instr slice holds its previous value.
- Program port:
  - prog_ready = 1 in RUN.
  - When prog_valid & prog_ready, mem[index] = prog_data at the clock edge.
  - Out-of-range or misaligned writes are dropped silently; the array is not modified.
- Read during write to the same word in the same cycle is read-first: the fetch returns the old contents, and the new data is visible from the next cycle onward.
- Reset asserted mid-CLEAR: the sweep restarts from 0.
- Reset asserted mid-RUN: in-flight fetch_valid is dropped immediately. The array is re-zeroed by a new sweep, so software must reload the program.
- Fetch latency is exactly 1 cycle. A port sustains one fetch per cycle.

Optional Feature:
Macro IMEM_WRITE_BYPASS_EN.
- Defined: a same-cycle fetch to the word being written by an accepted program write returns prog_data (write-first forwarding), per core, independently on each core.
- Undefined: read-first behaviour as specified above; no forwarding logic is built.

Test Plan:
- Release reset with DEPTH=64 -> init_done rises exactly 64 cycles later; fetch_gnt=0 throughout; a fetch at addr 0x08 after the sweep -> fetch_valid=1, instr=0x00000000, fault=0.
- Program write 0x20080003 @0x00 and 0x20090007 @0x04. Next cycle, core0 fetches 0x00 and core1 fetches 0x04 -> one cycle later core0=0x20080003, core1=0x20090007, both valid.
- Both cores fetch 0x10 in the same cycle, after 0xAC0A0010 was written there -> both ports return 0xAC0A0010 together, no stall.
- Core0 fetches 0x102 (misaligned), then 0x100 (index 64, out of range) -> instr=0 and fault=1 on each response; a program write to 0x100 leaves the array unchanged (verify via a sweep of reads).
- Program write 0x01095020 @0x08 while core1 fetches 0x08 in the same cycle:
  - Without the macro -> returns old value 0; a refetch returns 0x01095020.
  - With IMEM_WRITE_BYPASS_EN -> returns 0x01095020 immediately.
- Assert reset mid-RUN with fetch_valid=1, then release -> fetch_valid drops asynchronously; after the 64-cycle sweep, fetch of 0x00 returns 0.
